// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch buffer: queue entry layout,
// default depth and the value presented to decode when nothing is queued.
package fetch_pkg;

  localparam int unsigned FETCH_N     = 32;
  localparam int unsigned FETCH_DEPTH = 4;

  localparam logic [FETCH_N-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [FETCH_N-1:0] pc;
    logic [FETCH_N-1:0] instruction;
  } fetch_entry_t;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int unsigned fifo_count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic power-of-two FIFO with synchronous flush and a combinational head
// that reads zero while empty. Storage is cleared only by reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned W     = 2 * FETCH_N,
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = fifo_count_width(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[head_ptr];

  // Pointers are exactly log2(DEPTH) bits, so wrap is natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= tail_ptr + AW'(1);
      end
      if (do_pop) begin
        head_ptr <= head_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!reset) !(push && full)
  );

  a_count_in_range: assert property (
    @(posedge clk) disable iff (!reset) count <= CW'(DEPTH)
  );

endmodule

// File: rtl/fetch_buffer.sv
// Decouples fetch from decode: issues ROM reads at the fetch PC, captures the
// one-cycle-late response into a small queue and hands it to decode.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned N     = FETCH_N,
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc_in,
  input  logic         flush,
  output logic         fetch_stall,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_rdata,
  output logic         id_valid,
  input  logic         id_ready,
  output logic [N-1:0] id_pc,
  output logic [N-1:0] id_instruction
);

  localparam int unsigned CW = fifo_count_width(DEPTH);

  typedef struct packed {
    logic [N-1:0] pc;
    logic [N-1:0] instruction;
  } entry_t;

  logic          inflight;
  logic [N-1:0]  inflight_pc;
  entry_t        push_entry;
  entry_t        head_entry;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Count the outstanding read as occupied so its response always has a slot,
  // even if decode does not pop that cycle.
  assign occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign fetch_stall = fifo_full | (occupancy >= (CW + 1)'(DEPTH));

  assign imem_req  = reset & ~fetch_stall;
  assign imem_addr = pc_in;

  assign push       = inflight & ~flush;
  assign pop        = id_valid & id_ready;
  assign push_entry = '{pc: inflight_pc, instruction: imem_rdata};

  assign id_valid       = ~fifo_empty;
  assign id_pc          = fifo_empty ? '0 : head_entry.pc;
  assign id_instruction = fifo_empty ? N'(NOP_INSTR) : head_entry.instruction;

  // A request made in the flush cycle is kept: pc_in already holds the target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (imem_req) begin
      inflight    <= 1'b1;
      inflight_pc <= pc_in;
    end else begin
      inflight    <= 1'b0;
    end
  end

  fetch_fifo #(
    .W     (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_entry),
    .head      (head_entry),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_head_stable: assert property (
    @(posedge clk) disable iff (!reset)
      (id_valid && !id_ready && !flush) |=>
        (id_valid && $stable(id_pc) && $stable(id_instruction))
  );

  a_no_req_when_stalled: assert property (
    @(posedge clk) disable iff (!reset) !(imem_req && fetch_stall)
  );

endmodule
